// File: rtl/logic_unit_seq_if.sv
// Handshake bundle for logic_unit_seq: operand/command channel in, result channel out.
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid & ready are both 1.
interface logic_unit_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [2:0]       op_sel;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] z_out;
  logic [2:0]       op_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a_in, b_in, op_sel, mode, in_valid, out_ready,
    input  in_ready, z_out, op_out, out_valid
  );

  modport slave (
    input  a_in, b_in, op_sel, mode, in_valid, out_ready,
    output in_ready, z_out, op_out, out_valid
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Registered bitwise logic unit with a one-deep output register and a prescaled op sweep mode.
module logic_unit_seq #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic                clk,
  input  logic                rst,
  logic_unit_seq_if.slave     bus,
  output logic                o_dbg_state,
  output logic [2:0]          o_dbg_sweep_op
);
  localparam int PW = $clog2(DIV);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SWEEP = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic [2:0]       r_sweep_op;
  logic [2:0]       w_sweep_nxt;
  logic [WIDTH-1:0] r_z;
  logic [2:0]       r_op;
  logic             r_out_valid;
  logic             w_accept;
  logic [2:0]       w_op;

  function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] z;
    case (op)
      3'd0:    z = a & b;
      3'd1:    z = a | b;
      3'd2:    z = ~a;
      3'd3:    z = a ^ b;
      3'd4:    z = ~(a & b);
      3'd5:    z = ~(a | b);
      3'd6:    z = ~(a ^ b);
      default: z = a;
    endcase
    return z;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_MANUAL;
      r_presc    <= '0;
      r_sweep_op <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_sweep_op <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_sweep_nxt = r_sweep_op;
    case (r_state)
      ST_MANUAL: begin
        w_presc_nxt = '0;
        w_sweep_nxt = '0;
        if (bus.mode) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (!bus.mode) begin
          w_state_nxt = ST_MANUAL;
          w_presc_nxt = '0;
          w_sweep_nxt = '0;
        end else if (r_presc == PW'(DIV - 1)) begin
          w_presc_nxt = '0;
          w_sweep_nxt = r_sweep_op + 3'd1;
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      default: w_state_nxt = ST_MANUAL;
    endcase
  end

  // The registered sweep_op is used, so a step on the accept edge still sees the old code.
  assign w_op     = (r_state == ST_SWEEP) ? r_sweep_op : bus.op_sel;
  assign w_accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z         <= '0;
      r_op        <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_z         <= f_logic(w_op, bus.a_in, bus.b_in);
      r_op        <= w_op;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = ~r_out_valid | bus.out_ready;
  assign bus.z_out       = r_z;
  assign bus.op_out      = r_op;
  assign bus.out_valid   = r_out_valid;
  assign o_dbg_state     = r_state;
  assign o_dbg_sweep_op  = r_sweep_op;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: driver pushes expected {op,z}, monitor pops on each output transfer.
module tb_logic_unit_seq;
  localparam int W   = 4;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  logic dbg_state;
  logic [2:0] dbg_sweep_op;

  logic_unit_seq_if #(.WIDTH(W)) bus ();

  logic_unit_seq #(.WIDTH(W), .DIV(DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_sweep_op (dbg_sweep_op)
  );

  logic [W+2:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Hand-computed results for a=1100, b=1010, indexed by op code.
  logic [W-1:0] z_ab [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0110,
                             4'b0111, 4'b0001, 4'b1001, 4'b1100};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op_sel,
                      input logic [2:0] exp_op, input logic [W-1:0] exp_z);
    int wait_n;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.op_sel   = op_sel;
    bus.in_valid = 1'b1;
    wait_n = 0;
    @(negedge clk);
    while (!bus.in_ready && wait_n < 20) begin
      wait_n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back({exp_op, exp_z});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W+2:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {25'd0, bus.op_out, bus.z_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("result", {25'd0, bus.op_out, bus.z_out}, {25'd0, e});
        end
      end
    end
  end

  initial begin
    int t0;
    int wait_n;
    logic [W-1:0] z_held;
    rst = 1'b1;
    bus.a_in = '0; bus.b_in = '0; bus.op_sel = '0; bus.mode = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_z_out",     32'(bus.z_out),     32'd0);
    check("rst_op_out",    32'(bus.op_out),    32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_state",     32'(dbg_state),     32'd0);

    // 1: AND with one-cycle latency
    send(4'b1100, 4'b1010, 3'd0, 3'd0, 4'b1000);
    idle();
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_z_out",     32'(bus.z_out),     32'b1000);
    step(1);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // 2: ops 1..7 on the same operands
    for (int op = 1; op < 8; op++) send(4'b1100, 4'b1010, 3'(op), 3'(op), z_ab[op]);
    idle();
    step(2);

    // 3: stall holds result, then drain+accept in one cycle, then 8 back-to-back accepts
    bus.out_ready = 1'b0;
    send(4'b1111, 4'b0000, 3'd3, 3'd3, 4'b1111);
    bus.a_in = 4'b1111; bus.b_in = 4'b0000; bus.op_sel = 3'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    z_held = bus.z_out;
    check("stall_z", 32'(z_held), 32'b1111);
    repeat (2) @(negedge clk);
    check("stall_z_stable",  32'(bus.z_out),  32'(z_held));
    check("stall_op_stable", 32'(bus.op_out), 32'd3);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(4'b1111, 4'b0000, 3'd0, 3'd0, 4'b0000);
    check("reload_out_valid", 32'(bus.out_valid), 32'd1);
    t0 = cyc;
    send(4'b0110, 4'b0101, 3'd0, 3'd0, 4'b0100);
    send(4'b0110, 4'b0101, 3'd1, 3'd1, 4'b0111);
    send(4'b0110, 4'b0101, 3'd2, 3'd2, 4'b1001);
    send(4'b0110, 4'b0101, 3'd3, 3'd3, 4'b0011);
    send(4'b0110, 4'b0101, 3'd4, 3'd4, 4'b1011);
    send(4'b0110, 4'b0101, 3'd5, 3'd5, 4'b1000);
    send(4'b0110, 4'b0101, 3'd6, 3'd6, 4'b1100);
    send(4'b0110, 4'b0101, 3'd7, 3'd7, 4'b0110);
    idle();
    check("stream_8_in_8", 32'(cyc - t0), 32'd8);
    step(2);

    // 4: SWEEP, op steps every DIV accepts, wraps 7 -> 0
    bus.mode = 1'b1;
    step(1);
    for (int k = 0; k < 36; k++) send(4'b1100, 4'b1010, 3'd5, 3'((k / DIV) % 8), z_ab[(k / DIV) % 8]);
    idle();

    // 5: leave SWEEP mid-count, re-entry restarts at op 0 / prescaler 0
    step(6);
    bus.mode = 1'b0;
    step(2);
    check("back_to_manual",   32'(dbg_state),    32'd0);
    check("sweep_op_cleared", 32'(dbg_sweep_op), 32'd0);
    bus.mode = 1'b1;
    step(1);
    for (int k = 0; k < 5; k++) send(4'b1100, 4'b1010, 3'd7, 3'(k / DIV), z_ab[k / DIV]);
    idle();
    bus.mode = 1'b0;
    step(3);

    // 6: async reset between edges discards a pending result
    bus.out_ready = 1'b0;
    send(4'b1010, 4'b1010, 3'd6, 3'd6, 4'b1111);
    idle();
    check("pend_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_z_out",     32'(bus.z_out),     32'd0);
    check("arst_op_out",    32'(bus.op_out),    32'd0);
    exp_q.delete();
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    step(2);

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 20) begin
      wait_n++;
      step(1);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
